// File: rtl/memwb_pipe_stage.sv
// memwb_pipe_stage
//   MEM/WB pipeline register for the MIPS datapath. Carries the WB control bits
//   (RegWrite, MemtoReg), memory read data, ALU result and destination register
//   through STAGES register slices (latency = STAGES edges). Each slice carries a
//   valid bit. stall holds every slice, flush loads a bubble into slice 0, and a
//   RegWrite aimed at register 0 can be dropped on entry (ZERO_SUPP=1).
//
//   Optional feature (macro MEMWB_WBMUX_EN): adds out_wb_data, the WB-stage
//   write-back mux registered into the last slice.
//
// Parameters
//   DATA_W    width of memory data / ALU result
//   ADDR_W    width of destination register address
//   STAGES    number of register slices, 1..4
//   ZERO_SUPP 1: drop RegWrite to address 0 on entry
//
// Ports
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   stall, flush        hold all slices / insert bubble at slice 0
//   in_valid, in_wb     MEM-stage valid, {MemtoReg, RegWrite}
//   in_mem_data         data memory read data
//   in_alu_res          ALU result
//   in_wr_addr          destination register
//   out_valid           last slice holds a real instruction
//   out_reg_write       RegWrite of last slice qualified by out_valid
//   out_mem_to_reg      MemtoReg of last slice
//   out_mem_data        memory data of last slice
//   out_alu_res         ALU result of last slice
//   out_wr_addr         destination register of last slice
//   out_wb_data         (MEMWB_WBMUX_EN only) registered write-back data

module memwb_pipe_stage #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 5,
  parameter int unsigned STAGES    = 1,
  parameter int unsigned ZERO_SUPP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [1:0]        in_wb,
  input  logic [DATA_W-1:0] in_mem_data,
  input  logic [DATA_W-1:0] in_alu_res,
  input  logic [ADDR_W-1:0] in_wr_addr,
  output logic              out_valid,
  output logic              out_reg_write,
  output logic              out_mem_to_reg,
  output logic [DATA_W-1:0] out_mem_data,
  output logic [DATA_W-1:0] out_alu_res,
  output logic [ADDR_W-1:0] out_wr_addr
`ifdef MEMWB_WBMUX_EN
  ,
  output logic [DATA_W-1:0] out_wb_data
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("memwb_pipe_stage: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic              valid;
    logic              rw;
    logic              m2r;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] alu;
    logic [ADDR_W-1:0] addr;
  } slice_t;

  slice_t entry_d;
  slice_t slice_q [STAGES];

  // Entry presented to slice 0: a zeroed bubble under flush, otherwise the
  // MEM-stage inputs with RegWrite qualified by valid and the $zero check.
  always_comb begin
    entry_d = '0;
    if (!flush) begin
      entry_d.valid = in_valid;
      entry_d.rw    = in_wb[0] & in_valid &
                      ((ZERO_SUPP == 0) || (in_wr_addr != '0));
      entry_d.m2r   = in_wb[1];
      entry_d.mem   = in_mem_data;
      entry_d.alu   = in_alu_res;
      entry_d.addr  = in_wr_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        slice_q[k] <= '0;
      end
    end else if (!stall) begin
      slice_q[0] <= entry_d;
      for (int unsigned k = 1; k < STAGES; k++) begin
        slice_q[k] <= slice_q[k-1];
      end
    end
  end

  assign out_valid      = slice_q[STAGES-1].valid;
  assign out_reg_write  = slice_q[STAGES-1].rw & slice_q[STAGES-1].valid;
  assign out_mem_to_reg = slice_q[STAGES-1].m2r;
  assign out_mem_data   = slice_q[STAGES-1].mem;
  assign out_alu_res    = slice_q[STAGES-1].alu;
  assign out_wr_addr    = slice_q[STAGES-1].addr;

`ifdef MEMWB_WBMUX_EN
  // The mux is evaluated on the entry about to enter the last slice so the
  // write-back value is ready as a plain register output.
  slice_t            last_in;
  logic [DATA_W-1:0] wb_d;
  logic [DATA_W-1:0] wb_q;

  if (STAGES == 1) begin : g_last_from_in
    always_comb last_in = entry_d;
  end else begin : g_last_from_pipe
    always_comb last_in = slice_q[STAGES-2];
  end

  always_comb begin
    wb_d = '0;
    if (last_in.valid) begin
      wb_d = last_in.m2r ? last_in.mem : last_in.alu;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= wb_d;
    end
  end

  assign out_wb_data = wb_q;
`endif

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// tb_memwb_pipe_stage
//   Drives a STAGES=1 and a STAGES=3 instance (both ZERO_SUPP=1) with the same
//   directed vectors. Each accepted valid vector pushes its expected result into
//   one queue per instance; a monitor sampling 1 time unit after each rising edge
//   pops and compares whenever a new valid entry is presented, checks that
//   stalled edges hold, bubbles never write, and reset clears everything.

module tb_memwb_pipe_stage;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n    = 1'b0;
  logic        stall    = 1'b0;
  logic        flush    = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_wb    = '0;
  logic [31:0] in_mem   = '0;
  logic [31:0] in_alu   = '0;
  logic [4:0]  in_addr  = '0;

  logic        o1_valid, o1_rw, o1_m2r, o3_valid, o3_rw, o3_m2r;
  logic [31:0] o1_mem, o1_alu, o1_wb, o3_mem, o3_alu, o3_wb;
  logic [4:0]  o1_addr, o3_addr;

  memwb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .STAGES(1), .ZERO_SUPP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wb(in_wb), .in_mem_data(in_mem),
    .in_alu_res(in_alu), .in_wr_addr(in_addr),
    .out_valid(o1_valid), .out_reg_write(o1_rw), .out_mem_to_reg(o1_m2r),
    .out_mem_data(o1_mem), .out_alu_res(o1_alu), .out_wr_addr(o1_addr)
`ifdef MEMWB_WBMUX_EN
    , .out_wb_data(o1_wb)
`endif
  );

  memwb_pipe_stage #(.DATA_W(32), .ADDR_W(5), .STAGES(3), .ZERO_SUPP(1)) u3 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wb(in_wb), .in_mem_data(in_mem),
    .in_alu_res(in_alu), .in_wr_addr(in_addr),
    .out_valid(o3_valid), .out_reg_write(o3_rw), .out_mem_to_reg(o3_m2r),
    .out_mem_data(o3_mem), .out_alu_res(o3_alu), .out_wr_addr(o3_addr)
`ifdef MEMWB_WBMUX_EN
    , .out_wb_data(o3_wb)
`endif
  );

`ifndef MEMWB_WBMUX_EN
  assign o1_wb = '0;
  assign o3_wb = '0;
`endif

  typedef struct packed {
    logic        v;
    logic        rw;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [31:0] wb;
    logic [4:0]  addr;
  } ent_t;

  ent_t act1, act3;
  always_comb begin
    act1 = '{v: o1_valid, rw: o1_rw, m2r: o1_m2r, mem: o1_mem, alu: o1_alu,
             wb: o1_wb, addr: o1_addr};
    act3 = '{v: o3_valid, rw: o3_rw, m2r: o3_m2r, mem: o3_mem, alu: o3_alu,
             wb: o3_wb, addr: o3_addr};
  end

  ent_t q1[$];
  ent_t q3[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic chke(input string n, input ent_t act, input ent_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic judge(input string tag, input logic r, input logic s,
                       input ent_t a, input ent_t p, input ent_t e, input logic h);
    if (!r) begin
      chke({tag, " reset_clear"}, a, '0);
    end else if (s) begin
      chke({tag, " stall_hold"}, a, p);
    end else if (!a.v) begin
      chk({tag, " bubble_no_write"}, {31'b0, a.rw}, 32'd0);
    end else if (h) begin
      chke({tag, " entry"}, a, e);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s unexpected_entry: got %h expected no entry", tag, a);
    end
  endtask

  // Monitor: samples the control seen at the edge, then the outputs #1 later.
  initial begin
    ent_t p1, p3, a1, a3, e1, e3;
    logic r_s, s_s, h1, h3;
    p1 = '0;
    p3 = '0;
    forever begin
      @(posedge clk);
      r_s = rst_n;
      s_s = stall;
      #1;
      a1 = act1;
      a3 = act3;
      h1 = 1'b0;
      h3 = 1'b0;
      e1 = '0;
      e3 = '0;
      if (r_s && !s_s && a1.v && q1.size() > 0) begin
        e1 = q1.pop_front();
        h1 = 1'b1;
      end
      if (r_s && !s_s && a3.v && q3.size() > 0) begin
        e3 = q3.pop_front();
        h3 = 1'b1;
      end
      judge("u1", r_s, s_s, a1, p1, e1, h1);
      judge("u3", r_s, s_s, a3, p3, e3, h3);
      p1 = a1;
      p3 = a3;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Apply one vector; accepted valid vectors queue their expected result.
  task automatic setv(input logic r, input logic s, input logic f, input logic v,
                      input logic [1:0] wb, input logic [31:0] mem,
                      input logic [31:0] alu, input logic [4:0] addr);
    ent_t e;
    rst_n    = r;
    stall    = s;
    flush    = f;
    in_valid = v;
    in_wb    = wb;
    in_mem   = mem;
    in_alu   = alu;
    in_addr  = addr;
    if (!r) begin
      q1.delete();
      q3.delete();
    end else if (!s && !f && v) begin
      e.v    = 1'b1;
      e.rw   = wb[0] && (addr != 5'd0);
      e.m2r  = wb[1];
      e.mem  = mem;
      e.alu  = alu;
      e.addr = addr;
`ifdef MEMWB_WBMUX_EN
      e.wb   = wb[1] ? mem : alu;
`else
      e.wb   = '0;
`endif
      q1.push_back(e);
      q3.push_back(e);
    end
  endtask

  task automatic idle();
    setv(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // T1: reset with live-looking inputs
    tick(); setv(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
    tick(); setv(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'h1234_5678, 5'd3);
    tick();
    chk("T1 valid", {31'b0, o1_valid}, 32'd0);
    chk("T1 reg_write", {31'b0, o1_rw}, 32'd0);
    chk("T1 mem_to_reg", {31'b0, o1_m2r}, 32'd0);
    chk("T1 alu", o1_alu, 32'd0);
    chk("T1 addr", {27'b0, o1_addr}, 32'd0);
    // T2: single pass-through
    setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0000_00AA, 5'd8);
    tick();
    chk("T2 valid", {31'b0, o1_valid}, 32'd1);
    chk("T2 reg_write", {31'b0, o1_rw}, 32'd1);
    chk("T2 alu", o1_alu, 32'h0000_00AA);
    chk("T2 addr", {27'b0, o1_addr}, 32'd8);
    // T3: load addr 9, then stall three edges while inputs change
    setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 32'h0000_0055, 32'h0000_0066, 5'd9);
    tick();
    chk("T3 load addr", {27'b0, o1_addr}, 32'd9);
    setv(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 32'h1, 32'h2, 5'd10);
    tick();
    chk("T3 stall1 addr", {27'b0, o1_addr}, 32'd9);
    setv(1'b1, 1'b1, 1'b0, 1'b1, 2'b01, 32'h3, 32'h4, 5'd11);
    tick();
    chk("T3 stall2 addr", {27'b0, o1_addr}, 32'd9);
    // T4a: flush together with stall is ignored
    setv(1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 32'h5, 32'h6, 5'd12);
    tick();
    chk("T4 flush+stall addr", {27'b0, o1_addr}, 32'd9);
    chk("T4 flush+stall valid", {31'b0, o1_valid}, 32'd1);
    setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h7, 32'h8, 5'd13);
    tick();
    chk("T3 release addr", {27'b0, o1_addr}, 32'd13);
    // T4b: flush alone inserts a bubble
    setv(1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 32'h9, 32'hA, 5'd14);
    tick();
    chk("T4 flush valid", {31'b0, o1_valid}, 32'd0);
    chk("T4 flush reg_write", {31'b0, o1_rw}, 32'd0);
    // T5: write to $zero is suppressed but the entry stays valid
    setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0000_00BB, 5'd0);
    tick();
    chk("T5 valid", {31'b0, o1_valid}, 32'd1);
    chk("T5 reg_write", {31'b0, o1_rw}, 32'd0);
    chk("T5 alu", o1_alu, 32'h0000_00BB);
    idle();
    repeat (4) begin
      tick(); idle();
    end
    // T6: three-slice latency and write-back mux, then reset mid-flight
    tick(); setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd17);
    tick(); setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0000_0100, 5'd20);
    tick();
    chk("T6 early valid", {31'b0, o3_valid}, 32'd0);
    setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0, 32'h0000_0200, 5'd21);
    tick();
    chk("T6 valid", {31'b0, o3_valid}, 32'd1);
    chk("T6 reg_write", {31'b0, o3_rw}, 32'd1);
    chk("T6 mem", o3_mem, 32'hDEAD_BEEF);
`ifdef MEMWB_WBMUX_EN
    chk("T6 wb_data", o3_wb, 32'hDEAD_BEEF);
`endif
    setv(1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31);
    tick();
    chk("T6 reset valid", {31'b0, o3_valid}, 32'd0);
    chk("T6 reset alu", o3_alu, 32'd0);
    chk("T6 reset wb", o3_wb, 32'd0);
    idle();
    repeat (3) begin
      tick(); idle();
    end
    chk("T6 no ghost", {31'b0, o3_valid}, 32'd0);
    // Recovery after reset: RegWrite clear entry
    tick(); setv(1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0000_0300, 5'd22);
    repeat (5) begin
      tick(); idle();
    end
    chk("u1 queue drained", q1.size(), 32'd0);
    chk("u3 queue drained", q3.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
